// File: rtl/operate_frame_sender.sv
// Captures verified operate events into a small FIFO and serialises each one as a
// 4-byte frame (header, op, cuisine count, XOR checksum) on a valid/ready byte stream.
`timescale 1ns/1ps
module operate_frame_sender #(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter logic [7:0]  HDR_BYTE    = 8'hAA,
   parameter logic [7:0]  IGNORE_CODE = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] verified_op,
   input  logic [2:0] cuisine_num,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic [2:0] fifo_level,
   output logic       overflow,
   output logic       busy
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_OP,
      S_NUM,
      S_SUM
   } state_t;

   state_t        state_q, state_d;
   logic [10:0]   mem_q [FIFO_DEPTH];
   logic [10:0]   mem_d [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [2:0]    level_q, level_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    prev_op_q, prev_op_d;
   logic [7:0]    op_q, op_d;
   logic [2:0]    num_q, num_d;

   logic          fifo_empty;
   logic          fifo_full;
   logic          op_event;
   logic          push_req;
   logic          push;
   logic          pop;
   logic [10:0]   head;

   assign fifo_empty = (level_q == 3'd0);
   assign fifo_full  = (level_q == 3'(FIFO_DEPTH));
   assign op_event   = (verified_op != prev_op_q);
   assign push_req   = op_event && (verified_op != IGNORE_CODE);
   assign head       = mem_q[rd_ptr_q];

   // A new frame is loaded from idle, or straight after the checksum byte is taken.
   assign pop  = !fifo_empty && ((state_q == S_IDLE) || ((state_q == S_SUM) && tx_ready));
   assign push = push_req && (!fifo_full || pop);

   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      prev_op_d  = prev_op_q;
      if (op_event) begin
         prev_op_d = verified_op;
      end
      if (push) begin
         mem_d[wr_ptr_q] = {verified_op, cuisine_num};
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
         level_d = level_q + 3'd1;
      end else if (pop && !push) begin
         level_d = level_q - 3'd1;
      end
      if (push_req && !push) begin
         overflow_d = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      num_d   = num_q;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               op_d    = head[10:3];
               num_d   = head[2:0];
               state_d = S_HDR;
            end
         end
         S_HDR: begin
            if (tx_ready) begin
               state_d = S_OP;
            end
         end
         S_OP: begin
            if (tx_ready) begin
               state_d = S_NUM;
            end
         end
         S_NUM: begin
            if (tx_ready) begin
               state_d = S_SUM;
            end
         end
         S_SUM: begin
            if (tx_ready) begin
               if (pop) begin
                  op_d    = head[10:3];
                  num_d   = head[2:0];
                  state_d = S_HDR;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      tx_data = 8'h00;
      case (state_q)
         S_HDR:   tx_data = HDR_BYTE;
         S_OP:    tx_data = op_q;
         S_NUM:   tx_data = {5'b0, num_q};
         S_SUM:   tx_data = HDR_BYTE ^ op_q ^ {5'b0, num_q};
         default: tx_data = 8'h00;
      endcase
   end

   assign tx_valid   = (state_q != S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign fifo_level = level_q;
   assign overflow   = overflow_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= 3'd0;
         overflow_q <= 1'b0;
         prev_op_q  <= IGNORE_CODE;
         op_q       <= 8'h00;
         num_q      <= 3'd0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem_q[i] <= 11'd0;
         end
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         prev_op_q  <= prev_op_d;
         op_q       <= op_d;
         num_q      <= num_d;
         mem_q      <= mem_d;
      end
   end

endmodule

// File: tb/tb_operate_frame_sender.sv
// Self-checking bench for operate_frame_sender: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a queue-based frame model.
`timescale 1ns/1ps
module tb_operate_frame_sender;

   localparam int         DEPTH = 4;
   localparam logic [7:0] HDR   = 8'hAA;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] verified_op = 8'h00;
   logic [2:0] cuisine_num = 3'd0;
   logic       tx_ready = 1'b0;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic [2:0] fifo_level;
   logic       overflow;
   logic       busy;

   int checks = 0;
   int passes = 0;

   operate_frame_sender #(
      .FIFO_DEPTH (DEPTH),
      .HDR_BYTE   (HDR),
      .IGNORE_CODE(8'h00)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .verified_op(verified_op),
      .cuisine_num(cuisine_num),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .fifo_level (fifo_level),
      .overflow   (overflow),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
      end
   endtask

   // Reference model: pending events as a queue, the frame in flight as a 4-byte array.
   logic [7:0]  m_prev = 8'h00;
   logic [10:0] m_q[$];
   bit          m_ovf = 1'b0;
   bit          m_active = 1'b0;
   logic [7:0]  m_frame [4];
   int          m_idx = 0;
   bit          m_accepted, m_need_new;
   logic [10:0] m_ev;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_prev   = 8'h00;
         m_q.delete();
         m_ovf    = 1'b0;
         m_active = 1'b0;
         m_idx    = 0;
      end else begin
         m_accepted = m_active && tx_ready;
         m_need_new = !m_active || (m_accepted && m_idx == 3);
         if (m_need_new && m_q.size() > 0) begin
            m_ev       = m_q.pop_front();
            m_frame[0] = HDR;
            m_frame[1] = m_ev[10:3];
            m_frame[2] = {5'b0, m_ev[2:0]};
            m_frame[3] = HDR ^ m_ev[10:3] ^ {5'b0, m_ev[2:0]};
            m_idx      = 0;
            m_active   = 1'b1;
         end else if (m_accepted && m_idx == 3) begin
            m_active = 1'b0;
         end else if (m_accepted) begin
            m_idx++;
         end
         if (verified_op != m_prev) begin
            m_prev = verified_op;
            if (verified_op != 8'h00) begin
               if (m_q.size() < DEPTH) m_q.push_back({verified_op, cuisine_num});
               else m_ovf = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      check_output("tx_valid", {31'b0, tx_valid}, {31'b0, m_active});
      check_output("busy", {31'b0, busy}, {31'b0, m_active});
      check_output("tx_data", {24'b0, tx_data}, m_active ? {24'b0, m_frame[m_idx]} : 32'h0);
      check_output("fifo_level", {29'b0, fifo_level}, m_q.size());
      check_output("overflow", {31'b0, overflow}, {31'b0, m_ovf});
   end

   logic [7:0] acc_log[$];

   always @(negedge clk) begin
      if (rst_n && tx_valid && tx_ready) acc_log.push_back(tx_data);
   end

   function automatic logic [31:0] log_at(input int i);
      if (i < acc_log.size()) return {24'b0, acc_log[i]};
      return 32'hFFFF;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic apply_stimulus(input logic [7:0] op, input logic [2:0] num, input logic rdy);
      verified_op = op;
      cuisine_num = num;
      tx_ready    = rdy;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: actual timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      apply_stimulus(8'h00, 3'd0, 1'b0);
      tick(2);
      check_output("reset_tx_valid", {31'b0, tx_valid}, 32'd0);
      check_output("reset_tx_data", {24'b0, tx_data}, 32'd0);
      check_output("reset_level", {29'b0, fifo_level}, 32'd0);
      rst_n = 1'b1;
      tick(2);

      // Single event: valid appears two cycles after the change.
      acc_log.delete();
      apply_stimulus(8'h12, 3'd2, 1'b1);
      tick(1);
      check_output("single_valid_early", {31'b0, tx_valid}, 32'd0);
      tick(1);
      check_output("single_valid_on_time", {31'b0, tx_valid}, 32'd1);
      check_output("single_hdr", {24'b0, tx_data}, 32'hAA);
      tick(4);
      check_output("single_len", acc_log.size(), 32'd4);
      check_output("single_b0", log_at(0), 32'hAA);
      check_output("single_b1", log_at(1), 32'h12);
      check_output("single_b2", log_at(2), 32'h02);
      check_output("single_b3", log_at(3), 32'hBA);
      check_output("single_idle", {31'b0, tx_valid}, 32'd0);

      // Backpressure held on the OP byte.
      apply_stimulus(8'h00, 3'd2, 1'b1);
      tick(2);
      acc_log.delete();
      apply_stimulus(8'h12, 3'd2, 1'b1);
      tick(3);
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         check_output("bp_hold_data", {24'b0, tx_data}, 32'h12);
         check_output("bp_hold_valid", {31'b0, tx_valid}, 32'd1);
      end
      tx_ready = 1'b1;
      tick(3);
      check_output("bp_len", acc_log.size(), 32'd4);
      check_output("bp_b1", log_at(1), 32'h12);
      check_output("bp_b3", log_at(3), 32'hBA);

      // Ignore code and repeated ops.
      apply_stimulus(8'h00, 3'd5, 1'b1);
      tick(2);
      acc_log.delete();
      apply_stimulus(8'h12, 3'd5, 1'b1);
      tick(1);
      apply_stimulus(8'h00, 3'd5, 1'b1);
      tick(1);
      apply_stimulus(8'h12, 3'd5, 1'b1);
      tick(100);
      check_output("repeat_len", acc_log.size(), 32'd8);
      check_output("repeat_op1", log_at(1), 32'h12);
      check_output("repeat_op2", log_at(5), 32'h12);
      apply_stimulus(8'h00, 3'd5, 1'b1);
      tick(20);
      check_output("ignore_len", acc_log.size(), 32'd8);

      // Overflow with the transmitter stalled.
      for (int i = 0; i < 6; i++) begin
         apply_stimulus(8'h21 + 8'(i), 3'(i), 1'b0);
         tick(1);
      end
      tick(2);
      check_output("ovf_level", {29'b0, fifo_level}, 32'd4);
      check_output("ovf_flag", {31'b0, overflow}, 32'd1);
      check_output("ovf_hdr", {24'b0, tx_data}, 32'hAA);
      acc_log.delete();
      tx_ready = 1'b1;
      tick(20);
      check_output("ovf_burst_len", acc_log.size(), 32'd20);
      check_output("ovf_first_op", log_at(1), 32'h21);
      check_output("ovf_second_op", log_at(5), 32'h22);
      check_output("ovf_last_op", log_at(17), 32'h25);
      tick(1);
      check_output("ovf_drained", {31'b0, tx_valid}, 32'd0);

      // Push and pop together while full.
      apply_stimulus(8'h00, 3'd0, 1'b0);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(1);
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(8'h31 + 8'(i), 3'(i), 1'b0);
         tick(1);
      end
      tick(1);
      check_output("full_level", {29'b0, fifo_level}, 32'd4);
      tx_ready = 1'b1;
      tick(3);
      apply_stimulus(8'h36, 3'd3, 1'b1);
      tick(1);
      tx_ready = 1'b0;
      check_output("pushpop_level", {29'b0, fifo_level}, 32'd4);
      check_output("pushpop_ovf", {31'b0, overflow}, 32'd0);
      check_output("pushpop_hdr", {24'b0, tx_data}, 32'hAA);

      // Reset while the NUM byte is on the bus.
      tx_ready = 1'b1;
      tick(2);
      check_output("pre_reset_num", {24'b0, tx_data}, 32'h01);
      apply_stimulus(8'h00, 3'd0, 1'b0);
      rst_n = 1'b0;
      #1;
      check_output("reset_mid_valid", {31'b0, tx_valid}, 32'd0);
      check_output("reset_mid_level", {29'b0, fifo_level}, 32'd0);
      tick(2);
      rst_n = 1'b1;
      acc_log.delete();
      tx_ready = 1'b1;
      tick(3);
      check_output("post_reset_quiet", acc_log.size(), 32'd0);
      apply_stimulus(8'h47, 3'd6, 1'b1);
      tick(6);
      check_output("post_reset_len", acc_log.size(), 32'd4);
      check_output("post_reset_b0", log_at(0), 32'hAA);
      check_output("post_reset_b1", log_at(1), 32'h47);
      check_output("post_reset_b3", log_at(3), 32'hEB);

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         logic [7:0] op;
         op = verified_op;
         if ($urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 3))
               0:       op = 8'h00;
               1:       op = 8'h12;
               default: op = 8'($urandom_range(0, 255));
            endcase
         end
         apply_stimulus(op, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
         if (c == 1500) begin
            rst_n = 1'b0;
            tick(1);
            rst_n = 1'b1;
         end
         tick(1);
      end
      tx_ready = 1'b1;
      tick(40);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
